// File: rtl/msrv32_instr_decoder.sv
// msrv32 stage-2 instruction decoder.
// Turns opcode/funct fields into registered control for the execute/write-back stages.
module msrv32_instr_decoder (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       trap_taken_in,
  input  logic       funct7_5_in,
  input  logic [6:0] opcode_in,
  input  logic [2:0] funct3_in,
  input  logic [1:0] iadder_out_1_to_0_in,
  output logic [2:0] wb_mux_sel_out,
  output logic [2:0] imm_type_out,
  output logic [2:0] csr_op_out,
  output logic       mem_wr_req_out,
  output logic [3:0] alu_opcode_out,
  output logic [1:0] load_size_out,
  output logic       load_unsigned_out,
  output logic       alu_src_out,
  output logic       iadder_src_out,
  output logic       csr_wr_en_out,
  output logic       rf_wr_en_out,
  output logic       illegal_instr_out,
  output logic       misaligned_load_out,
  output logic       misaligned_store_out
);

  typedef struct packed {
    logic [2:0] wb_mux_sel;
    logic [2:0] imm_type;
    logic [2:0] csr_op;
    logic       mem_wr_req;
    logic [3:0] alu_opcode;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       alu_src;
    logic       iadder_src;
    logic       csr_wr_en;
    logic       rf_wr_en;
    logic       illegal;
    logic       mis_load;
    logic       mis_store;
  } dec_t;

  dec_t d;
  dec_t q;

  logic [4:0] cls;
  logic [1:0] addr;
  logic is_load, is_misc, is_op_imm, is_auipc;
  logic is_store, is_op, is_lui, is_branch;
  logic is_jalr, is_jal, is_system, is_csr;
  logic known, illegal, misaligned;

  assign cls  = opcode_in[6:2];
  assign addr = iadder_out_1_to_0_in;

  assign is_load   = cls == 5'b00000;
  assign is_misc   = cls == 5'b00011;
  assign is_op_imm = cls == 5'b00100;
  assign is_auipc  = cls == 5'b00101;
  assign is_store  = cls == 5'b01000;
  assign is_op     = cls == 5'b01100;
  assign is_lui    = cls == 5'b01101;
  assign is_branch = cls == 5'b11000;
  assign is_jalr   = cls == 5'b11001;
  assign is_jal    = cls == 5'b11011;
  assign is_system = cls == 5'b11100;
  assign is_csr    = is_system & (funct3_in != 3'b000);

  assign known = is_load | is_misc | is_op_imm
               | is_auipc | is_store | is_op
               | is_lui | is_branch | is_jalr
               | is_jal | is_system;

  assign illegal = (opcode_in[1:0] != 2'b11) | ~known;

  // half needs addr[0] clear; word (and funct3 x11) needs both clear
  assign misaligned =
      ((funct3_in[1:0] == 2'b01) & addr[0])
    | (funct3_in[1] & (addr != 2'b00));

  always_comb begin
    d = '0;
    d.illegal = illegal;
    d.alu_opcode = {
      funct7_5_in & (is_op
        | (is_op_imm & (funct3_in == 3'b101))),
      funct3_in};
    d.alu_src       = opcode_in[5];
    d.iadder_src    = is_load | is_store | is_jalr;
    d.load_size     = funct3_in[1:0];
    d.load_unsigned = funct3_in[2];
    d.csr_op        = funct3_in;
    d.csr_wr_en     = is_csr & ~illegal;
    d.rf_wr_en = ~illegal & (is_lui | is_auipc
      | is_jal | is_jalr | is_op | is_op_imm
      | is_load | is_csr);
    d.wb_mux_sel[0] = is_load | is_auipc
                    | is_jal | is_jalr;
    d.wb_mux_sel[1] = is_lui | is_auipc;
    d.wb_mux_sel[2] = is_csr | is_jal | is_jalr;
    d.imm_type[0] = is_op_imm | is_load | is_jalr
                  | is_branch | is_jal;
    d.imm_type[1] = is_store | is_branch | is_csr;
    d.imm_type[2] = is_lui | is_auipc
                  | is_jal | is_csr;
    d.mis_load   = is_load & misaligned
                 & ~trap_taken_in;
    d.mis_store  = is_store & misaligned
                 & ~trap_taken_in;
    d.mem_wr_req = is_store & ~misaligned
                 & ~trap_taken_in & ~illegal;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) q <= '0;
    else         q <= d;
  end

  assign wb_mux_sel_out       = q.wb_mux_sel;
  assign imm_type_out         = q.imm_type;
  assign csr_op_out           = q.csr_op;
  assign mem_wr_req_out       = q.mem_wr_req;
  assign alu_opcode_out       = q.alu_opcode;
  assign load_size_out        = q.load_size;
  assign load_unsigned_out    = q.load_unsigned;
  assign alu_src_out          = q.alu_src;
  assign iadder_src_out       = q.iadder_src;
  assign csr_wr_en_out        = q.csr_wr_en;
  assign rf_wr_en_out         = q.rf_wr_en;
  assign illegal_instr_out    = q.illegal;
  assign misaligned_load_out  = q.mis_load;
  assign misaligned_store_out = q.mis_store;

endmodule

// File: tb/tb_msrv32_instr_decoder.sv
// Bench for msrv32_instr_decoder: directed table,
// reset corners and random vectors against a class-level model.
module tb_msrv32_instr_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trap;
  logic       f7;
  logic [6:0] op;
  logic [2:0] f3;
  logic [1:0] ad;

  logic [2:0] wb, imm, csr_op;
  logic [3:0] alu;
  logic [1:0] ls;
  logic mem_wr, lu, alu_src, iad, csr_wr;
  logic rf_wr, ill, mis_l, mis_s;

  typedef struct packed {
    logic [2:0] wb;
    logic [2:0] imm;
    logic [2:0] csr_op;
    logic       mem;
    logic [3:0] alu;
    logic [1:0] ls;
    logic       lu;
    logic       src;
    logic       iad;
    logic       cw;
    logic       rf;
    logic       ill;
    logic       ml;
    logic       ms;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] ad;
    logic       tr;
    out_t       exp;
  } vec_t;

  typedef enum {
    C_BAD, C_LOAD, C_MISC, C_OPIMM, C_AUIPC,
    C_STORE, C_OP, C_LUI, C_BRANCH, C_JALR,
    C_JAL, C_SYS
  } cls_e;

  int vectors = 0;
  int miscompares = 0;

  msrv32_instr_decoder dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .trap_taken_in        (trap),
    .funct7_5_in          (f7),
    .opcode_in            (op),
    .funct3_in            (f3),
    .iadder_out_1_to_0_in (ad),
    .wb_mux_sel_out       (wb),
    .imm_type_out         (imm),
    .csr_op_out           (csr_op),
    .mem_wr_req_out       (mem_wr),
    .alu_opcode_out       (alu),
    .load_size_out        (ls),
    .load_unsigned_out    (lu),
    .alu_src_out          (alu_src),
    .iadder_src_out       (iad),
    .csr_wr_en_out        (csr_wr),
    .rf_wr_en_out         (rf_wr),
    .illegal_instr_out    (ill),
    .misaligned_load_out  (mis_l),
    .misaligned_store_out (mis_s)
  );

  always #5 clk = ~clk;

  function automatic out_t e(
    logic [2:0] wb_, logic [2:0] imm_,
    logic [2:0] csr_, logic mem_,
    logic [3:0] alu_, logic [1:0] ls_,
    logic lu_, logic src_, logic iad_,
    logic cw_, logic rf_, logic ill_,
    logic ml_, logic ms_);
    out_t o;
    o = '{wb_, imm_, csr_, mem_, alu_, ls_, lu_,
          src_, iad_, cw_, rf_, ill_, ml_, ms_};
    return o;
  endfunction

  function automatic out_t model(
    logic [6:0] o_op, logic [2:0] o_f3,
    logic o_f7, logic [1:0] o_ad, logic o_tr);
    out_t o;
    cls_e c;
    bit csr, bad, mis;
    int bytes;
    o = '0;
    case (o_op[6:2])
      5'd0:  c = C_LOAD;
      5'd3:  c = C_MISC;
      5'd4:  c = C_OPIMM;
      5'd5:  c = C_AUIPC;
      5'd8:  c = C_STORE;
      5'd12: c = C_OP;
      5'd13: c = C_LUI;
      5'd24: c = C_BRANCH;
      5'd25: c = C_JALR;
      5'd27: c = C_JAL;
      5'd28: c = C_SYS;
      default: c = C_BAD;
    endcase
    csr = (c == C_SYS) && (o_f3 != 0);
    bad = (o_op[1:0] != 2'b11) || (c == C_BAD);
    bytes = o_f3[1] ? 4 : (o_f3[1:0] == 2'b01 ? 2 : 1);
    mis = (int'(o_ad) % bytes) != 0;
    o.ill = bad;
    o.alu = {o_f7 && (c == C_OP ||
             (c == C_OPIMM && o_f3 == 3'd5)), o_f3};
    o.src = o_op[5];
    o.iad = c inside {C_LOAD, C_STORE, C_JALR};
    o.ls = o_f3[1:0];
    o.lu = o_f3[2];
    o.csr_op = o_f3;
    o.cw = csr && !bad;
    o.rf = !bad && (csr || c inside {C_LUI, C_AUIPC,
           C_JAL, C_JALR, C_OP, C_OPIMM, C_LOAD});
    if (c == C_LOAD) o.wb = 3'd1;
    else if (c == C_LUI) o.wb = 3'd2;
    else if (c == C_AUIPC) o.wb = 3'd3;
    else if (csr) o.wb = 3'd4;
    else if (c inside {C_JAL, C_JALR}) o.wb = 3'd5;
    if (csr) o.imm = 3'd6;
    else case (c)
      C_OPIMM, C_LOAD, C_JALR: o.imm = 3'd1;
      C_STORE:  o.imm = 3'd2;
      C_BRANCH: o.imm = 3'd3;
      C_LUI, C_AUIPC: o.imm = 3'd4;
      C_JAL:    o.imm = 3'd5;
      default:  o.imm = 3'd0;
    endcase
    o.ml = (c == C_LOAD) && mis && !o_tr;
    o.ms = (c == C_STORE) && mis && !o_tr;
    o.mem = (c == C_STORE) && !mis && !o_tr && !bad;
    return o;
  endfunction

  function automatic out_t got();
    return '{wb, imm, csr_op, mem_wr, alu, ls, lu,
             alu_src, iad, csr_wr, rf_wr, ill,
             mis_l, mis_s};
  endfunction

  task automatic check(string name, out_t exp);
    out_t g;
    g = got();
    vectors++;
    if (g !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, g, exp);
    end
  endtask

  task automatic drive(logic [6:0] i_op,
    logic [2:0] i_f3, logic i_f7,
    logic [1:0] i_ad, logic i_tr);
    op = i_op; f3 = i_f3; f7 = i_f7;
    ad = i_ad; trap = i_tr;
  endtask

  vec_t tbl[17];
  logic [6:0] legal_ops[11];

  initial begin
    tbl[0]  = '{"op_add", 7'b0110011, 3'd0, 1'b0, 2'd0, 1'b0,
      e(0,0,0,0,4'h0,0,0,1,0,0,1,0,0,0)};
    tbl[1]  = '{"op_sub", 7'b0110011, 3'd0, 1'b1, 2'd0, 1'b0,
      e(0,0,0,0,4'h8,0,0,1,0,0,1,0,0,0)};
    tbl[2]  = '{"slti", 7'b0010011, 3'd2, 1'b0, 2'd1, 1'b0,
      e(0,1,2,0,4'h2,2,0,0,0,0,1,0,0,0)};
    tbl[3]  = '{"srai", 7'b0010011, 3'd5, 1'b1, 2'd0, 1'b0,
      e(0,1,5,0,4'hd,1,1,0,0,0,1,0,0,0)};
    tbl[4]  = '{"ld_mis", 7'b0000011, 3'd3, 1'b0, 2'd2, 1'b0,
      e(1,1,3,0,4'h3,3,1'b0,0,1,0,1,0,1,0)};
    tbl[5]  = '{"lbu", 7'b0000011, 3'd4, 1'b0, 2'd3, 1'b0,
      e(1,1,4,0,4'h4,0,1,0,1,0,1,0,0,0)};
    tbl[6]  = '{"st_mis", 7'b0100011, 3'd7, 1'b0, 2'd3, 1'b0,
      e(0,2,7,0,4'h7,3,1,1,1,0,0,0,0,1)};
    tbl[7]  = '{"sw", 7'b0100011, 3'd2, 1'b0, 2'd0, 1'b0,
      e(0,2,2,1,4'h2,2,0,1,1,0,0,0,0,0)};
    tbl[8]  = '{"bltu", 7'b1100011, 3'd6, 1'b0, 2'd0, 1'b0,
      e(0,3,6,0,4'h6,2,1,1,0,0,0,0,0,0)};
    tbl[9]  = '{"jal", 7'b1101111, 3'd0, 1'b0, 2'd0, 1'b0,
      e(5,5,0,0,4'h0,0,0,1,0,0,1,0,0,0)};
    tbl[10] = '{"jalr", 7'b1100111, 3'd0, 1'b0, 2'd0, 1'b0,
      e(5,1,0,0,4'h0,0,0,1,1,0,1,0,0,0)};
    tbl[11] = '{"lui_trap", 7'b0110111, 3'd0, 1'b0, 2'd0, 1'b1,
      e(2,4,0,0,4'h0,0,0,1,0,0,1,0,0,0)};
    tbl[12] = '{"ill_low", 7'b0110001, 3'd0, 1'b0, 2'd0, 1'b0,
      e(0,0,0,0,4'h0,0,0,1,0,0,0,1,0,0)};
    tbl[13] = '{"csrrw", 7'b1110011, 3'd1, 1'b0, 2'd0, 1'b0,
      e(4,6,1,0,4'h1,1,0,1,0,1,1,0,0,0)};
    tbl[14] = '{"sw_trap", 7'b0100011, 3'd2, 1'b0, 2'd0, 1'b1,
      e(0,2,2,0,4'h2,2,0,1,1,0,0,0,0,0)};
    tbl[15] = '{"ill_cls", 7'b1111111, 3'd2, 1'b0, 2'd0, 1'b0,
      e(0,0,2,0,4'h2,2,0,1,0,0,0,1,0,0)};
    tbl[16] = '{"ecall", 7'b1110011, 3'd0, 1'b0, 2'd0, 1'b0,
      e(0,0,0,0,4'h0,0,0,1,0,0,0,0,0,0)};

    legal_ops = '{7'b0000011, 7'b0001111, 7'b0010011,
      7'b0010111, 7'b0100011, 7'b0110011, 7'b0110111,
      7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011};

    drive(7'b0110011, 3'd0, 1'b0, 2'd0, 1'b0);
    #2;
    check("reset_state", '0);
    @(posedge clk); #1;
    check("reset_held", '0);
    rst_n = 1'b1;
    #1;
    check("after_release", '0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7,
            tbl[i].ad, tbl[i].tr);
      @(posedge clk); #1;
      check(tbl[i].name, tbl[i].exp);
    end

    // async reset mid-stream, then recovery
    drive(7'b0110111, 3'd0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_lui",
      e(2,4,0,0,4'h0,0,0,1,0,0,1,0,0,0));
    drive(7'b0110001, 3'd0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    check("pre_reset_ill",
      e(0,0,0,0,4'h0,0,0,1,0,0,0,1,0,0));
    #1 rst_n = 1'b0;
    #1;
    check("async_clear", '0);
    @(posedge clk); #1;
    check("clear_held", '0);
    #1 rst_n = 1'b1;
    #1;
    check("no_edge_yet", '0);
    @(posedge clk); #1;
    check("first_after_rst", model(op, f3, f7, ad, trap));

    for (int i = 0; i < 400; i++) begin
      logic [6:0] r_op;
      logic [2:0] r_f3;
      logic r_f7, r_tr;
      logic [1:0] r_ad;
      if ($urandom_range(0, 9) < 8)
        r_op = legal_ops[$urandom_range(0, 10)];
      else
        r_op = 7'($urandom);
      r_f3 = 3'($urandom);
      r_f7 = 1'($urandom);
      r_ad = 2'($urandom);
      r_tr = ($urandom_range(0, 3) == 0);
      drive(r_op, r_f3, r_f7, r_ad, r_tr);
      @(posedge clk); #1;
      check("random", model(r_op, r_f3, r_f7, r_ad, r_tr));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
